// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: parametrised N x N image-display controller.
// Loads an image from IROM, runs single-cycle 2x2 window commands around an
// operation point, and streams the whole image to IRAM on the write command.
module lcd_ctrl_param #(
  parameter  int DW    = 8,
  parameter  int LOG_N = 3,
  localparam int AW    = 2 * LOG_N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = 1 << LOG_N;
  localparam int NN = N * N;
  localparam logic [LOG_N-1:0] MID      = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] LO_LIMIT = LOG_N'(1);
  localparam logic [LOG_N-1:0] HI_LIMIT = LOG_N'(N - 1);
  localparam logic [AW-1:0]    LAST     = AW'(NN - 1);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    IDLE  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  logic [LOG_N-1:0] x;
  logic [LOG_N-1:0] y;
  logic [3:0]       op;
  logic [DW-1:0]    mem [NN];

  // Window addresses, window pixels and their replacement values.
  logic [AW-1:0]   a0, a1, a2, a3;
  logic [DW-1:0]   p0, p1, p2, p3;
  logic [DW-1:0]   n0, n1, n2, n3;
  logic [DW-1:0]   max01, max23, max_all;
  logic [DW-1:0]   min01, min23, min_all;
  logic [DW+1:0]   sum;
  logic [DW-1:0]   avg;
  logic [AW-1:0]   wr_next;

  // Window geometry and the per-command new pixel values for EXEC.
  always_comb begin
    a0 = {y - LO_LIMIT, x - LO_LIMIT};
    a1 = {y - LO_LIMIT, x};
    a2 = {y, x - LO_LIMIT};
    a3 = {y, x};
    p0 = mem[a0];
    p1 = mem[a1];
    p2 = mem[a2];
    p3 = mem[a3];
    max01   = (p0 > p1) ? p0 : p1;
    max23   = (p2 > p3) ? p2 : p3;
    max_all = (max01 > max23) ? max01 : max23;
    min01   = (p0 < p1) ? p0 : p1;
    min23   = (p2 < p3) ? p2 : p3;
    min_all = (min01 < min23) ? min01 : min23;
    // Sum is two bits wider than a pixel so four pixels never overflow.
    sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    avg = sum[DW+1:2];
    wr_next = IRAM_A + AW'(1);
    n0 = p0;
    n1 = p1;
    n2 = p2;
    n3 = p3;
    case (op)
      4'd5: begin n0 = max_all; n1 = max_all; n2 = max_all; n3 = max_all; end
      4'd6: begin n0 = min_all; n1 = min_all; n2 = min_all; n3 = min_all; end
      4'd7: begin n0 = avg;     n1 = avg;     n2 = avg;     n3 = avg;     end
      4'd8: begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
      4'd9: begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
      4'd10: begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
      4'd11: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
      default: begin n0 = p0; n1 = p1; n2 = p2; n3 = p3; end
    endcase
  end

  // Pixel array: filled from IROM during LOAD, window rewritten in EXEC.
  // Contents are not reset; they are always reloaded after reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && IROM_rd) begin
      mem[IROM_A] <= IROM_Q;
    end else if (state == EXEC) begin
      mem[a0] <= n0;
      mem[a1] <= n1;
      mem[a2] <= n2;
      mem[a3] <= n3;
    end
  end

  // Control FSM with registered outputs and operation-point tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      x          <= MID;
      y          <= MID;
      op         <= 4'd0;
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_D     <= '0;
      IRAM_A     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // First cycle after reset only raises the read enable.
          if (!IROM_rd) begin
            IROM_rd <= 1'b1;
          end else if (IROM_A == LAST) begin
            IROM_rd <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            IROM_A <= IROM_A + AW'(1);
          end
        end
        IDLE: begin
          if (cmd_valid && !busy) begin
            busy <= 1'b1;
            op   <= cmd;
            if (cmd == 4'd0) begin
              state      <= WRITE;
              IRAM_valid <= 1'b1;
              IRAM_A     <= '0;
              IRAM_D     <= mem[0];
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          case (op)
            4'd1: if (y > LO_LIMIT) y <= y - LO_LIMIT;
            4'd2: if (y < HI_LIMIT) y <= y + LO_LIMIT;
            4'd3: if (x > LO_LIMIT) x <= x - LO_LIMIT;
            4'd4: if (x < HI_LIMIT) x <= x + LO_LIMIT;
            4'd12: begin
              x <= MID;
              y <= MID;
            end
            default: begin
              x <= x;
            end
          endcase
          busy  <= 1'b0;
          state <= IDLE;
        end
        WRITE: begin
          if (IRAM_A == LAST) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            IRAM_A <= wr_next;
            IRAM_D <= mem[wr_next];
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b1;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
